axis_packet_gen: RTL and testbench
==================================

Name: axis_packet_gen

Overview:
AXI-Stream transmitter that generates configurable test packets toward the slave port of the stream processing block. It supports a configurable packet count, beat count, final-beat byte count, inter-packet gap and data pattern. It obeys tready backpressure and reports progress. It is the bring-up and BIST source for the stream processing path.

Parameters:
TDATA_WIDTH, 32, stream data width in bits, multiple of 8; LFSR mode is defined for 32 only.
LEN_WIDTH, 16, width of the packet-count and beat-count configuration inputs.
GAP_WIDTH, 8, width of the inter-packet gap configuration.
LFSR_TAPS, 32'h80200003, Galois LFSR feedback mask.

Ports:
aclk  in  1  clock; all logic on the rising edge.
areset  in  1  synchronous, active-high reset.
start  in  1  pulse; latches the configuration and begins a run; ignored while busy.
abort  in  1  pulse; the run ends after the packet in flight completes.
num_packets  in  LEN_WIDTH  packets per run; 0 means empty run.
beats_per_pkt  in  LEN_WIDTH  beats per packet; 0 is treated as 1.
last_bytes  in  8  valid bytes in the final beat; 0 or >= TDATA_WIDTH/8 means full.
gap_cycles  in  GAP_WIDTH  idle cycles between packets.
pattern  in  2  data pattern: 0 incrementing, 1 constant, 2 LFSR, 3 walking-one.
seed  in  TDATA_WIDTH  initial data value.
m_axis_tdata  out  TDATA_WIDTH  stream data.
m_axis_tkeep  out  TDATA_WIDTH/8  byte enables.
m_axis_tlast  out  1  final beat of a packet.
m_axis_tvalid  out  1  beat valid.
m_axis_tready  in  1  downstream ready.
busy  out  1  high while state is not IDLE.
done  out  1  one-cycle pulse at the end of a run.
pkts_sent  out  LEN_WIDTH  packets completed in the current or last run; cleared on start.

Behaviour:
- The interface uses one clock, aclk. Reset, areset, is synchronous and active-high.
- Reset state (takes effect on the next edge, including mid-packet): state IDLE. tvalid, tlast, done, busy = 0. tdata = 0, tkeep = 0, pkts_sent = 0. Reset mid-packet truncates the packet; this is allowed only under reset.
- States:
  - IDLE -> SEND on start.
  - SEND -> GAP after a tlast handshake when gap_cycles > 0 and packets remain.
  - SEND -> SEND after a tlast handshake when gap_cycles = 0 and packets remain.
  - SEND -> DONE after a tlast handshake when no packets remain or abort has been latched.
  - GAP -> SEND after gap_cycles cycles.
  - DONE -> IDLE unconditionally, after 1 cycle.
- Timing:
  - start sampled at edge N: tvalid = 1 with the first beat from edge N+1.
  - num_packets = 0: go directly to DONE, no beats, done pulses at N+1.
- Configuration is latched on start. Input changes during a run have no effect.
- Handshake rules:
  - A beat transfers when tvalid & tready.
  - Once tvalid is high, tdata, tkeep and tlast are held stable until the handshake.
  - tvalid never deasserts without a handshake, except on reset.
  - The data and beat counters advance only on a handshake.
- Gaps:
  - With gap_cycles = G > 0, tvalid is low for exactly G cycles after the tlast handshake.
  - With G = 0, the next packet's first beat is presented on the cycle after the tlast handshake, with tvalid held high.
- tkeep and tlast:
  - tkeep is all ones except on the last beat, where bits [last_bytes-1:0] are set and the rest cleared (LSB-aligned).
  - tlast = 1 only on beat beats_per_pkt-1.
- Patterns (the value advances per handshaked beat and is continuous across packets in a run):
  - 0: seed, seed+1, ..., modulo 2^TDATA_WIDTH (wraps to 0).
  - 1: constant seed.
  - 2: Galois LFSR, next = lsb ? (x>>1)^LFSR_TAPS : x>>1. Seed 0 is replaced by 1.
  - 3: starts at 1 and rotates left by 1 per beat (bit W-1 wraps to bit 0).
- Status:
  - pkts_sent increments on each tlast handshake.
  - abort pulses are latched until the run ends. abort while IDLE is ignored. abort during GAP ends the run at the end of the gap without sending a packet.
  - done = 1 for one cycle in state DONE; busy falls on the same edge that done falls.
- start while busy, including in DONE, is ignored.

Test Plan:
- Basic packets: seed=0x10, pattern 0, num_packets=2, beats_per_pkt=3, gap=0, tready=1 -> data 0x10..0x15; tlast on 0x12 and 0x15; tvalid continuous 6 cycles; done pulses; pkts_sent=2.
- Backpressure: pattern 0, seed=0x12345678, 4 beats; tready low for 3 cycles while beat 1 is presented -> 0x12345679 held stable; then 0x1234567A, 0x1234567B follow; no beat lost or duplicated.
- Partial last beat and gap: beats_per_pkt=2, last_bytes=2, gap=4, num_packets=2 -> tkeep 0xF then 0x3; tvalid low exactly 4 cycles between packets.
- Wrap and walking-one: pattern 0 with seed=0xFFFFFFFF, 2 beats -> 0xFFFFFFFF, 0x00000000. Pattern 3, 33 beats -> 0x1, 0x2, ..., 0x80000000, 0x1.
- Abort, empty run and LFSR: abort during packet 1 of 5 -> packet 1 completes with tlast; pkts_sent=1; done pulses. num_packets=0 -> done at N+1 with no tvalid. Pattern 2 with seed=0 -> first beat 0x00000001, next 0x80200003.
- Reset mid-packet: areset high mid-packet -> tvalid=0 at the next edge; busy=0; pkts_sent=0; a new start afterwards begins cleanly from the seed.

Source files
------------

// File: rtl/axis_packet_gen.sv
// AXI-Stream test packet generator: configurable packet/beat counts, partial
// final beat, inter-packet gap and data pattern, with tready backpressure.
module axis_packet_gen #(
    parameter int          TDATA_WIDTH = 32,
    parameter int          LEN_WIDTH   = 16,
    parameter int          GAP_WIDTH   = 8,
    parameter logic [31:0] LFSR_TAPS   = 32'h80200003
) (
    input  logic                       aclk,
    input  logic                       areset,
    input  logic                       start,
    input  logic                       abort,
    input  logic [LEN_WIDTH-1:0]       num_packets,
    input  logic [LEN_WIDTH-1:0]       beats_per_pkt,
    input  logic [7:0]                 last_bytes,
    input  logic [GAP_WIDTH-1:0]       gap_cycles,
    input  logic [1:0]                 pattern,
    input  logic [TDATA_WIDTH-1:0]     seed,
    output logic [TDATA_WIDTH-1:0]     m_axis_tdata,
    output logic [TDATA_WIDTH/8-1:0]   m_axis_tkeep,
    output logic                       m_axis_tlast,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic                       busy,
    output logic                       done,
    output logic [LEN_WIDTH-1:0]       pkts_sent
);

    localparam int                     BYTES    = TDATA_WIDTH / 8;
    localparam logic [7:0]             BYTES_8  = 8'(BYTES);
    localparam logic [TDATA_WIDTH-1:0] ONE_D    = {{(TDATA_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [TDATA_WIDTH-1:0] TAPS     = TDATA_WIDTH'(LFSR_TAPS);
    localparam logic [LEN_WIDTH-1:0]   ONE_L    = {{(LEN_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [LEN_WIDTH-1:0]   ZERO_L   = {LEN_WIDTH{1'b0}};
    localparam logic [GAP_WIDTH-1:0]   ONE_G    = {{(GAP_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [GAP_WIDTH-1:0]   ZERO_G   = {GAP_WIDTH{1'b0}};
    localparam logic [BYTES-1:0]       KEEP_ALL = {BYTES{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic logic [TDATA_WIDTH-1:0] first_data(input logic [1:0] pat,
                                                          input logic [TDATA_WIDTH-1:0] s);
        logic [TDATA_WIDTH-1:0] v;
        case (pat)
            2'd2:    v = (s == {TDATA_WIDTH{1'b0}}) ? ONE_D : s;
            2'd3:    v = ONE_D;
            default: v = s;
        endcase
        return v;
    endfunction

    function automatic logic [TDATA_WIDTH-1:0] next_data(input logic [1:0] pat,
                                                         input logic [TDATA_WIDTH-1:0] x);
        logic [TDATA_WIDTH-1:0] v;
        case (pat)
            2'd0:    v = x + ONE_D;
            2'd2:    v = x[0] ? ((x >> 1) ^ TAPS) : (x >> 1);
            2'd3:    v = {x[TDATA_WIDTH-2:0], x[TDATA_WIDTH-1]};
            default: v = x;
        endcase
        return v;
    endfunction

    // LSB-aligned byte mask; 0 or a full-width count means every byte valid
    function automatic logic [BYTES-1:0] keep_for(input logic [7:0] lb);
        logic [BYTES-1:0] k;
        for (int i = 0; i < BYTES; i++) begin
            k[i] = (lb == 8'd0) || (lb >= BYTES_8) || (8'(i) < lb);
        end
        return k;
    endfunction

    state_t                  state_r, state_n;
    logic [LEN_WIDTH-1:0]    npkt_r, npkt_n;
    logic [LEN_WIDTH-1:0]    beats_r, beats_n;
    logic [BYTES-1:0]        keep_last_r, keep_last_n;
    logic [GAP_WIDTH-1:0]    gap_cfg_r, gap_cfg_n;
    logic [1:0]              pat_r, pat_n;
    logic [TDATA_WIDTH-1:0]  data_r, data_n;
    logic [LEN_WIDTH-1:0]    beat_r, beat_n;
    logic [LEN_WIDTH-1:0]    pkts_r, pkts_n;
    logic [GAP_WIDTH-1:0]    gap_cnt_r, gap_cnt_n;
    logic                    abort_r, abort_n;
    logic                    tvalid_r, tvalid_n;
    logic                    tlast_r, tlast_n;
    logic [BYTES-1:0]        tkeep_r, tkeep_n;
    logic                    done_r, done_n;
    logic                    busy_r, busy_n;

    logic                    hs_s;
    logic                    abort_any_s;
    logic                    last_pkt_s;
    logic [LEN_WIDTH-1:0]    beats_start_s;
    logic                    start_last_s;
    logic                    beat0_last_s;
    logic                    next_last_s;

    assign hs_s          = tvalid_r & m_axis_tready;
    assign abort_any_s   = abort_r | abort;
    assign last_pkt_s    = ({1'b0, pkts_r} + {ZERO_L, 1'b1}) >= {1'b0, npkt_r};
    assign beats_start_s = (beats_per_pkt == ZERO_L) ? ONE_L : beats_per_pkt;
    assign start_last_s  = (beats_start_s == ONE_L);
    assign beat0_last_s  = (beats_r == ONE_L);
    assign next_last_s   = ((beat_r + ONE_L) == (beats_r - ONE_L));

    // Next-state, counter and output-register computation
    always_comb begin
        state_n     = state_r;
        npkt_n      = npkt_r;
        beats_n     = beats_r;
        keep_last_n = keep_last_r;
        gap_cfg_n   = gap_cfg_r;
        pat_n       = pat_r;
        data_n      = data_r;
        beat_n      = beat_r;
        pkts_n      = pkts_r;
        gap_cnt_n   = gap_cnt_r;
        abort_n     = abort_r;
        tvalid_n    = tvalid_r;
        tlast_n     = tlast_r;
        tkeep_n     = tkeep_r;

        case (state_r)
            IDLE: begin
                abort_n = 1'b0;
                if (start) begin
                    npkt_n      = num_packets;
                    beats_n     = beats_start_s;
                    keep_last_n = keep_for(last_bytes);
                    gap_cfg_n   = gap_cycles;
                    pat_n       = pattern;
                    data_n      = first_data(pattern, seed);
                    beat_n      = ZERO_L;
                    pkts_n      = ZERO_L;
                    if (num_packets == ZERO_L) begin
                        state_n  = DONE;
                        tvalid_n = 1'b0;
                        tlast_n  = 1'b0;
                    end else begin
                        state_n  = SEND;
                        tvalid_n = 1'b1;
                        tlast_n  = start_last_s;
                        tkeep_n  = start_last_s ? keep_for(last_bytes) : KEEP_ALL;
                    end
                end else begin
                    tvalid_n = 1'b0;
                end
            end
            SEND: begin
                abort_n = abort_any_s;
                if (hs_s) begin
                    data_n = next_data(pat_r, data_r);
                    if (tlast_r) begin
                        pkts_n = pkts_r + ONE_L;
                        beat_n = ZERO_L;
                        if (last_pkt_s || abort_any_s) begin
                            state_n  = DONE;
                            tvalid_n = 1'b0;
                            tlast_n  = 1'b0;
                        end else if (gap_cfg_r != ZERO_G) begin
                            state_n   = GAP;
                            gap_cnt_n = gap_cfg_r;
                            tvalid_n  = 1'b0;
                            tlast_n   = 1'b0;
                        end else begin
                            tvalid_n = 1'b1;
                            tlast_n  = beat0_last_s;
                            tkeep_n  = beat0_last_s ? keep_last_r : KEEP_ALL;
                        end
                    end else begin
                        beat_n  = beat_r + ONE_L;
                        tlast_n = next_last_s;
                        tkeep_n = next_last_s ? keep_last_r : KEEP_ALL;
                    end
                end else begin
                    tvalid_n = 1'b1;
                end
            end
            GAP: begin
                abort_n = abort_any_s;
                if (gap_cnt_r <= ONE_G) begin
                    if (abort_any_s) begin
                        state_n = DONE;
                    end else begin
                        state_n  = SEND;
                        tvalid_n = 1'b1;
                        tlast_n  = beat0_last_s;
                        tkeep_n  = beat0_last_s ? keep_last_r : KEEP_ALL;
                    end
                end else begin
                    gap_cnt_n = gap_cnt_r - ONE_G;
                end
            end
            DONE: begin
                state_n  = IDLE;
                abort_n  = 1'b0;
                tvalid_n = 1'b0;
            end
            default: begin
                state_n  = IDLE;
                tvalid_n = 1'b0;
            end
        endcase

        done_n = (state_n == DONE);
        busy_n = (state_n != IDLE);
    end

    // State, configuration and output registers with synchronous reset
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_r     <= IDLE;
            npkt_r      <= ZERO_L;
            beats_r     <= ONE_L;
            keep_last_r <= KEEP_ALL;
            gap_cfg_r   <= ZERO_G;
            pat_r       <= 2'd0;
            data_r      <= {TDATA_WIDTH{1'b0}};
            beat_r      <= ZERO_L;
            pkts_r      <= ZERO_L;
            gap_cnt_r   <= ZERO_G;
            abort_r     <= 1'b0;
            tvalid_r    <= 1'b0;
            tlast_r     <= 1'b0;
            tkeep_r     <= {BYTES{1'b0}};
            done_r      <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_n;
            npkt_r      <= npkt_n;
            beats_r     <= beats_n;
            keep_last_r <= keep_last_n;
            gap_cfg_r   <= gap_cfg_n;
            pat_r       <= pat_n;
            data_r      <= data_n;
            beat_r      <= beat_n;
            pkts_r      <= pkts_n;
            gap_cnt_r   <= gap_cnt_n;
            abort_r     <= abort_n;
            tvalid_r    <= tvalid_n;
            tlast_r     <= tlast_n;
            tkeep_r     <= tkeep_n;
            done_r      <= done_n;
            busy_r      <= busy_n;
        end
    end

    assign m_axis_tdata  = data_r;
    assign m_axis_tkeep  = tkeep_r;
    assign m_axis_tlast  = tlast_r;
    assign m_axis_tvalid = tvalid_r;
    assign busy          = busy_r;
    assign done          = done_r;
    assign pkts_sent     = pkts_r;

endmodule

// File: tb/tb_axis_packet_gen.sv
// Directed self-checking bench for axis_packet_gen: inputs change 1 ns after the
// rising edge, outputs are sampled on the falling edge.
module tb_axis_packet_gen;

    localparam int W = 32;
    localparam int L = 16;
    localparam int G = 8;

    logic           aclk = 1'b0;
    logic           areset, start, abort;
    logic [L-1:0]   num_packets, beats_per_pkt;
    logic [7:0]     last_bytes;
    logic [G-1:0]   gap_cycles;
    logic [1:0]     pattern;
    logic [W-1:0]   seed;
    logic [W-1:0]   m_axis_tdata;
    logic [W/8-1:0] m_axis_tkeep;
    logic           m_axis_tlast, m_axis_tvalid, m_axis_tready;
    logic           busy, done;
    logic [L-1:0]   pkts_sent;

    axis_packet_gen #(.TDATA_WIDTH(W), .LEN_WIDTH(L), .GAP_WIDTH(G)) dut (
        .aclk(aclk), .areset(areset), .start(start), .abort(abort),
        .num_packets(num_packets), .beats_per_pkt(beats_per_pkt),
        .last_bytes(last_bytes), .gap_cycles(gap_cycles), .pattern(pattern),
        .seed(seed), .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
        .m_axis_tlast(m_axis_tlast), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .busy(busy), .done(done),
        .pkts_sent(pkts_sent)
    );

    always #5 aclk = ~aclk;

    int n_checks = 0;
    int n_pass   = 0;
    int edge_cnt = 0;

    logic [W-1:0]   cap_data[$];
    logic [W/8-1:0] cap_keep[$];
    logic           cap_last[$];
    logic           tv_log[$];

    // Rising-edge counter used to time done against the start edge
    always @(posedge aclk) edge_cnt <= edge_cnt + 1;

    // Beat capture (a handshake visible here completes at the next rising edge)
    always @(negedge aclk) begin
        if (m_axis_tvalid && m_axis_tready) begin
            cap_data.push_back(m_axis_tdata);
            cap_keep.push_back(m_axis_tkeep);
            cap_last.push_back(m_axis_tlast);
        end
        tv_log.push_back(m_axis_tvalid);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic clear_mon();
        cap_data.delete();
        cap_keep.delete();
        cap_last.delete();
        tv_log.delete();
    endtask

    task automatic cfg(input int n, input int b, input int lb, input int g,
                       input int p, input logic [W-1:0] s);
        num_packets   = L'(n);
        beats_per_pkt = L'(b);
        last_bytes    = 8'(lb);
        gap_cycles    = G'(g);
        pattern       = 2'(p);
        seed          = s;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Waits for done; checks it is a single-cycle pulse and busy drops with it
    task automatic wait_done(input string tag, input int limit, output int dedge);
        bit seen;
        seen  = 1'b0;
        dedge = -1;
        for (int c = 0; c < limit; c++) begin
            @(negedge aclk);
            if (done) begin
                seen  = 1'b1;
                dedge = edge_cnt;
                break;
            end
        end
        check({tag, "_done_seen"}, 64'(seen), 64'd1);
        @(negedge aclk);
        check({tag, "_done_one_cycle"}, 64'(done), 64'd0);
        check({tag, "_busy_low"}, 64'(busy), 64'd0);
        tick();
    endtask

    function automatic int count_high();
        int h = 0;
        foreach (tv_log[i]) if (tv_log[i]) h++;
        return h;
    endfunction

    // Idle cycles between the first and second tvalid-high runs; -1 if no second run
    function automatic int zeros_between();
        int i = 0;
        int z = 0;
        while (i < tv_log.size() && !tv_log[i]) i++;
        while (i < tv_log.size() && tv_log[i]) i++;
        while (i < tv_log.size() && !tv_log[i]) begin
            z++;
            i++;
        end
        if (i >= tv_log.size()) z = -1;
        return z;
    endfunction

    int dedge, e0;
    logic [W-1:0] exp_w;

    initial begin
        areset = 1'b1; start = 1'b0; abort = 1'b0; m_axis_tready = 1'b1;
        cfg(0, 0, 0, 0, 0, 32'h0);
        repeat (3) tick();
        @(negedge aclk);
        check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_tdata_tkeep_tlast", {27'd0, m_axis_tkeep, m_axis_tlast, m_axis_tdata}, 64'd0);
        check("rst_pkts", 64'(pkts_sent), 64'd0);
        tick();
        areset = 1'b0;
        tick();

        // Basic: two 3-beat packets, no gap, incrementing from 0x10
        clear_mon();
        cfg(2, 3, 0, 0, 0, 32'h10);
        pulse_start();
        wait_done("basic", 40, dedge);
        check("basic_nbeats", 64'(cap_data.size()), 64'd6);
        for (int i = 0; i < 6 && i < cap_data.size(); i++) begin
            check($sformatf("basic_data%0d", i), 64'(cap_data[i]), 64'(32'h10 + i));
            check($sformatf("basic_last%0d", i), 64'(cap_last[i]), 64'(i == 2 || i == 5));
        end
        check("basic_keep", 64'(cap_keep[5]), 64'hF);
        check("basic_tvalid_cycles", 64'(count_high()), 64'd6);
        check("basic_tvalid_contig", 64'(zeros_between()), 64'hFFFF_FFFF_FFFF_FFFF);
        check("basic_pkts", 64'(pkts_sent), 64'd2);

        // Backpressure while beat 1 is presented
        clear_mon();
        cfg(1, 4, 0, 0, 0, 32'h12345678);
        pulse_start();
        tick();
        m_axis_tready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge aclk);
            check($sformatf("bp_hold_data%0d", i), 64'(m_axis_tdata), 64'h12345679);
            check($sformatf("bp_hold_valid%0d", i), 64'(m_axis_tvalid), 64'd1);
            tick();
        end
        m_axis_tready = 1'b1;
        wait_done("bp", 40, dedge);
        check("bp_nbeats", 64'(cap_data.size()), 64'd4);
        for (int i = 0; i < 4 && i < cap_data.size(); i++)
            check($sformatf("bp_data%0d", i), 64'(cap_data[i]), 64'(32'h12345678 + i));
        check("bp_last", 64'(cap_last[3]), 64'd1);

        // Partial last beat with a 4-cycle gap, constant pattern
        clear_mon();
        cfg(2, 2, 2, 4, 1, 32'hA5A5A5A5);
        pulse_start();
        wait_done("gap", 60, dedge);
        check("gap_nbeats", 64'(cap_data.size()), 64'd4);
        for (int i = 0; i < 4 && i < cap_data.size(); i++) begin
            check($sformatf("gap_keep%0d", i), 64'(cap_keep[i]), (i % 2 == 1) ? 64'h3 : 64'hF);
            check($sformatf("gap_data%0d", i), 64'(cap_data[i]), 64'hA5A5A5A5);
        end
        check("gap_idle_cycles", 64'(zeros_between()), 64'd4);

        // Incrementing wrap
        clear_mon();
        cfg(1, 2, 0, 0, 0, 32'hFFFFFFFF);
        pulse_start();
        wait_done("wrap", 20, dedge);
        check("wrap_d0", 64'(cap_data[0]), 64'hFFFFFFFF);
        check("wrap_d1", 64'(cap_data[1]), 64'h0);

        // Walking one over 33 beats
        clear_mon();
        cfg(1, 33, 0, 0, 3, 32'h0);
        pulse_start();
        wait_done("walk", 80, dedge);
        check("walk_nbeats", 64'(cap_data.size()), 64'd33);
        for (int i = 0; i < 33 && i < cap_data.size(); i++) begin
            exp_w = (i < 32) ? (32'h1 << i) : 32'h1;
            check($sformatf("walk_d%0d", i), 64'(cap_data[i]), 64'(exp_w));
        end
        check("walk_last", 64'(cap_last[32]), 64'd1);

        // Abort during packet 1 of 5
        clear_mon();
        cfg(5, 4, 0, 0, 0, 32'h0);
        pulse_start();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        wait_done("abort", 60, dedge);
        check("abort_nbeats", 64'(cap_data.size()), 64'd4);
        check("abort_last", 64'(cap_last[3]), 64'd1);
        check("abort_pkts", 64'(pkts_sent), 64'd1);

        // Empty run: done visible right after the start edge, no tvalid
        clear_mon();
        cfg(0, 4, 0, 0, 0, 32'h55);
        e0 = edge_cnt;
        pulse_start();
        wait_done("empty", 10, dedge);
        check("empty_done_edge", 64'(dedge), 64'(e0 + 1));
        check("empty_no_tvalid", 64'(count_high()), 64'd0);
        check("empty_pkts", 64'(pkts_sent), 64'd0);

        // LFSR with seed 0
        clear_mon();
        cfg(1, 2, 0, 0, 2, 32'h0);
        pulse_start();
        wait_done("lfsr", 20, dedge);
        check("lfsr_d0", 64'(cap_data[0]), 64'h00000001);
        check("lfsr_d1", 64'(cap_data[1]), 64'h80200003);

        // Reset mid-packet, then a clean restart
        clear_mon();
        cfg(3, 8, 0, 0, 0, 32'h100);
        pulse_start();
        repeat (3) tick();
        areset = 1'b1;
        tick();
        @(negedge aclk);
        check("mrst_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("mrst_busy", 64'(busy), 64'd0);
        check("mrst_pkts", 64'(pkts_sent), 64'd0);
        tick();
        areset = 1'b0;
        tick();
        clear_mon();
        cfg(1, 2, 0, 0, 0, 32'h200);
        pulse_start();
        wait_done("restart", 20, dedge);
        check("restart_nbeats", 64'(cap_data.size()), 64'd2);
        check("restart_d0", 64'(cap_data[0]), 64'h200);
        check("restart_d1", 64'(cap_data[1]), 64'h201);
        check("restart_pkts", 64'(pkts_sent), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
